uart_word_assembler: RTL and testbench
======================================

# uart_word_assembler

Receive-side byte-to-word assembler for the debug unit. It takes the byte stream delivered by the UART receiver and packs every four consecutive bytes into one 32-bit word, so the host can load instructions and data into the pipeline memories. It is the inverse of the transmit-side 4:1 byte selection that serializes pipeline words toward the host. It sits between the UART RX core and the debug-unit control FSM. It also provides an inter-byte timeout, so a truncated transfer cannot leave a stale partial word behind.

## Interface
Parameters:
- `NB_BYTE`, 8, width of one received byte
- `N_BYTES`, 4, bytes per word; `NB = NB_BYTE*N_BYTES` = 32
- `NB_INDEX`, 2, width of the byte index (`clog2(N_BYTES)`)
- `TIMEOUT`, 50000, idle clocks allowed between bytes of one word
- `NB_TIMER`, 16, width of the timeout counter; must satisfy `TIMEOUT < 2^NB_TIMER`

Ports:
- `i_clock` in, 1: single clock.
- `i_reset` in, 1: synchronous, active-high reset.
- `i_rx_done` in, 1: one-cycle strobe from UART RX meaning `i_rx_data` is valid.
- `i_rx_data` in, `NB_BYTE`: received byte.
- `i_flush` in, 1: discard any partial word and return to IDLE.
- `o_word` out, `NB`: last completed word; holds until the next completion.
- `o_word_valid` out, 1: one-cycle pulse when `o_word` updates.
- `o_byte_index` out, `NB_INDEX`: number of bytes held in the current partial word (0..3).
- `o_busy` out, 1: high while in COLLECT.
- `o_timeout_err` out, 1: one-cycle pulse when a partial word is dropped by timeout.

## Operation
- Byte order is little-endian. Byte k of a word (k = 0..3, in arrival order) lands in `o_word[8k+7:8k]`.
- Internal state: shift/assembly register `NB` wide, byte counter `NB_INDEX`+1 bits, timer `NB_TIMER` bits, and the FSM below.
- FSM states:
  - IDLE: counter = 0, timer = 0. On `i_rx_done`: store the byte at index 0, counter=1, go to COLLECT.
  - COLLECT: on `i_rx_done`, store the byte at index = counter, counter+1, timer cleared.
    - When the 4th byte is stored, copy the assembled word to `o_word` and go to VALID.
    - With no byte, timer+1. When timer reaches `TIMEOUT-1` without a byte: clear counter, pulse `o_timeout_err`, go to IDLE.
  - VALID (one cycle): `o_word_valid`=1, counter=0. If `i_rx_done` arrives in this cycle, the byte is accepted as byte 0 of the next word and the next state is COLLECT; otherwise the next state is IDLE.
- `i_flush` takes priority over everything except reset:
  - counter=0, timer=0, next state IDLE.
  - A byte arriving in the same cycle is dropped.
  - `o_word` is not modified. `o_word_valid` is suppressed if flush coincides with VALID.
- `i_rx_done` in the same cycle as timeout expiry: the byte wins, the timer is cleared and no error is raised.
- The timer never wraps; it saturates at `TIMEOUT-1`.

## Timing
- Reset values: `o_word`=0, `o_word_valid`=0, `o_byte_index`=0, `o_busy`=0, `o_timeout_err`=0, FSM=IDLE, assembly register=0.
- Reset asserted mid-word discards the partial word; no pulse is generated.
- Latency: `o_word_valid` rises exactly 1 clock after the 4th `i_rx_done` cycle. `o_word` is valid on that same cycle and stays stable afterwards.
- Back-to-back bytes on consecutive clocks are accepted with no throughput loss: a sustained stream yields one word per 4 clocks.
- `o_byte_index` and `o_busy` are registered and reflect state after the edge that consumed a byte.
- No back-pressure toward the RX side; the consumer must sample `o_word` while `o_word_valid`=1 or before the next completion.

## Structure
- Shared package/header contents:
  - FSM state encodings IDLE=2'b00, COLLECT=2'b01, VALID=2'b10.
  - `NB_BYTE` and `N_BYTES` constants, shared with the transmit-side serializer.
- One sub-module is natural: `timeout_counter` (enable, clear, saturating count, `o_expired`), reusable by the debug-unit FSM.
- Everything else lives in a single always block for the FSM and one for the datapath.

## Test plan
- Reset, then bytes 0x78,0x56,0x34,0x12 on consecutive clocks -> one clock later `o_word`=0x12345678 with a single `o_word_valid` pulse; `o_byte_index` returns to 0.
- 8 consecutive bytes 0x01..0x08, one per clock -> two pulses 4 clocks apart, words 0x04030201 then 0x08070605. The 5th byte arrives in the VALID cycle and is accepted.
- 2 bytes, then idle for `TIMEOUT` clocks (TIMEOUT=20) -> `o_timeout_err` pulses once, `o_busy`=0, `o_word` unchanged. The next 4 bytes assemble correctly from index 0.
- Byte arriving on the exact expiry cycle -> no error, counter advances, word completes normally.
- 3 bytes, then `i_flush` together with a 4th byte -> no `o_word_valid`, byte dropped, `o_byte_index`=0. The following 4 bytes yield the correct word.
- `i_reset` asserted after 3 bytes of a word -> all outputs at reset values; a following clean 4-byte word is correct and `o_word` shows no residue.

Source files
------------

// File: rtl/uart_word_assembler_pkg.sv
// Shared constants and FSM encoding for the receive-side byte-to-word assembler.
package uart_word_assembler_pkg;

  // Byte geometry, shared with the transmit-side serializer.
  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned N_BYTES = 4;

  // Assembler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_VALID   = 2'b10
  } state_e;

endpackage : uart_word_assembler_pkg

// File: rtl/uart_word_assembler_timeout_counter.sv
// Saturating idle timer with a registered expiry flag; clear has priority over enable.
module timeout_counter #(
  parameter int unsigned TIMEOUT  = 50000,
  parameter int unsigned NB_TIMER = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam logic [NB_TIMER-1:0] LIMIT = NB_TIMER'(TIMEOUT - 1);

  logic [NB_TIMER-1:0] count_q;

  // Count enabled cycles up to LIMIT and hold there; flag goes high with the count reaching LIMIT.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      count_q   <= '0;
      o_expired <= (LIMIT == '0);
    end else if (i_enable && (count_q != LIMIT)) begin
      count_q   <= count_q + NB_TIMER'(1);
      o_expired <= (count_q == (LIMIT - NB_TIMER'(1)));
    end
  end

endmodule : timeout_counter

// File: rtl/uart_word_assembler.sv
// Packs four consecutive UART RX bytes (little-endian) into one 32-bit word,
// with an inter-byte timeout and a flush that drops any partial word.
module uart_word_assembler #(
  parameter int unsigned NB_BYTE  = uart_word_assembler_pkg::NB_BYTE,
  parameter int unsigned N_BYTES  = uart_word_assembler_pkg::N_BYTES,
  parameter int unsigned NB_INDEX = 2,
  parameter int unsigned TIMEOUT  = 50000,
  parameter int unsigned NB_TIMER = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_rx_done,
  input  logic [NB_BYTE-1:0]         i_rx_data,
  input  logic                       i_flush,
  output logic [NB_BYTE*N_BYTES-1:0] o_word,
  output logic                       o_word_valid,
  output logic [NB_INDEX-1:0]        o_byte_index,
  output logic                       o_busy,
  output logic                       o_timeout_err
);

  import uart_word_assembler_pkg::*;

  localparam int unsigned NB     = NB_BYTE * N_BYTES;
  localparam int unsigned NB_CNT = NB_INDEX + 1;

  state_e            state_q;
  state_e            state_d;
  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;
  logic [NB-1:0]     asm_q;
  logic [NB-1:0]     word_c;
  logic              accept_c;
  logic              complete_c;
  logic              timeout_c;
  logic              tmr_en_c;
  logic              tmr_clr_c;
  logic              tmr_expired;

  // Idle-time supervisor for the partial word.
  timeout_counter #(
    .TIMEOUT  (TIMEOUT),
    .NB_TIMER (NB_TIMER)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_enable  (tmr_en_c),
    .i_clear   (tmr_clr_c),
    .o_expired (tmr_expired)
  );

  // Assembly register with the incoming byte dropped into its slot.
  always_comb begin
    word_c = asm_q;
    for (int unsigned k = 0; k < N_BYTES; k++) begin
      if (cnt_q == NB_CNT'(k)) begin
        word_c[k*NB_BYTE +: NB_BYTE] = i_rx_data;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, byte counter and datapath strobes; flush overrides any byte.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_c   = 1'b0;
    complete_c = 1'b0;
    timeout_c  = 1'b0;
    tmr_en_c   = 1'b0;
    tmr_clr_c  = 1'b1;

    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_rx_done) begin
            accept_c = 1'b1;
            cnt_d    = NB_CNT'(1);
            state_d  = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (i_rx_done) begin
            accept_c = 1'b1;
            if (cnt_q == NB_CNT'(N_BYTES - 1)) begin
              complete_c = 1'b1;
              cnt_d      = '0;
              state_d    = ST_VALID;
            end else begin
              cnt_d = cnt_q + NB_CNT'(1);
            end
          end else if (tmr_expired) begin
            timeout_c = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            tmr_en_c  = 1'b1;
            tmr_clr_c = 1'b0;
          end
        end
        ST_VALID: begin
          // A byte landing in the VALID cycle starts the next word.
          if (i_rx_done) begin
            accept_c = 1'b1;
            cnt_d    = NB_CNT'(1);
            state_d  = ST_COLLECT;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: assembly register, byte counter and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q         <= '0;
      asm_q         <= '0;
      o_word        <= '0;
      o_word_valid  <= 1'b0;
      o_byte_index  <= '0;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept_c) begin
        asm_q <= word_c;
      end
      if (complete_c) begin
        o_word <= word_c;
      end
      o_word_valid  <= complete_c;
      o_timeout_err <= timeout_c;
      o_busy        <= (state_d == ST_COLLECT);
      o_byte_index  <= cnt_d[NB_INDEX-1:0];
    end
  end

endmodule : uart_word_assembler

// File: tb/tb_uart_word_assembler.sv
// Directed self-checking bench for uart_word_assembler (TIMEOUT shortened to 20).
module tb_uart_word_assembler;

  localparam int unsigned TO = 20;

  logic        clk;
  logic        rst;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        flush;
  logic [31:0] word;
  logic        word_valid;
  logic [1:0]  byte_index;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int pulses;

  uart_word_assembler #(
    .NB_BYTE  (8),
    .N_BYTES  (4),
    .NB_INDEX (2),
    .TIMEOUT  (TO),
    .NB_TIMER (16)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_rx_done     (rx_done),
    .i_rx_data     (rx_data),
    .i_flush       (flush),
    .o_word        (word),
    .o_word_valid  (word_valid),
    .o_byte_index  (byte_index),
    .o_busy        (busy),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one clock.
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word"},  word,        32'h0);
    check({tag, "_valid"}, word_valid,  32'h0);
    check({tag, "_index"}, byte_index,  32'h0);
    check({tag, "_busy"},  busy,        32'h0);
    check({tag, "_terr"},  timeout_err, 32'h0);
  endtask

  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    flush   = 1'b0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single word, consecutive bytes.
    send(8'h78); send(8'h56); send(8'h34);
    check("w1_index3", byte_index, 32'd3);
    check("w1_busy",   busy,       32'd1);
    send(8'h12);
    check("w1_valid",  word_valid, 32'd1);
    check("w1_word",   word,       32'h12345678);
    check("w1_index0", byte_index, 32'd0);
    tick();
    check("w1_valid_drop", word_valid, 32'd0);
    check("w1_word_hold",  word,       32'h12345678);
    check("w1_busy_idle",  busy,       32'd0);

    // Eight back-to-back bytes: two words, fifth byte lands in VALID cycle.
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      if (word_valid) pulses++;
      if (i == 4) begin
        check("s_valid4", word_valid, 32'd1);
        check("s_word4",  word,       32'h04030201);
      end
      if (i == 5) begin
        check("s_valid5", word_valid, 32'd0);
        check("s_index5", byte_index, 32'd1);
        check("s_busy5",  busy,       32'd1);
      end
    end
    check("s_valid8", word_valid, 32'd1);
    check("s_word8",  word,       32'h08070605);
    check("s_pulses", pulses,     32'd2);
    tick();

    // Two bytes then idle until the timeout drops them.
    send(8'hAA); send(8'hBB);
    pulses = 0;
    for (int i = 0; i < int'(TO) - 1; i++) begin
      tick();
      if (timeout_err) pulses++;
    end
    check("to_early_err", pulses, 32'd0);
    check("to_busy_pre",  busy,   32'd1);
    tick();
    check("to_err",   timeout_err, 32'd1);
    check("to_busy",  busy,        32'd0);
    check("to_index", byte_index,  32'd0);
    check("to_word",  word,        32'h08070605);
    tick();
    check("to_err_drop", timeout_err, 32'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("to_next_valid", word_valid, 32'd1);
    check("to_next_word",  word,       32'h44332211);
    tick();

    // Byte on the exact expiry cycle wins over the timeout.
    send(8'h55);
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    send(8'h66);
    check("ex_err",   timeout_err, 32'd0);
    check("ex_index", byte_index,  32'd2);
    check("ex_busy",  busy,        32'd1);
    send(8'h77);
    check("ex_err2",  timeout_err, 32'd0);
    send(8'h88);
    check("ex_valid", word_valid, 32'd1);
    check("ex_word",  word,       32'h88776655);
    tick();

    // Flush coinciding with the fourth byte.
    send(8'h9A); send(8'hBC); send(8'hDE);
    flush   = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'hF0;
    tick();
    flush   = 1'b0;
    rx_done = 1'b0;
    check("fl_valid", word_valid, 32'd0);
    check("fl_index", byte_index, 32'd0);
    check("fl_busy",  busy,       32'd0);
    check("fl_word",  word,       32'h88776655);
    tick();
    check("fl_valid_after", word_valid, 32'd0);
    send(8'h01); send(8'h23); send(8'h45); send(8'h67);
    check("fl_next_valid", word_valid, 32'd1);
    check("fl_next_word",  word,       32'h67452301);
    tick();

    // Reset in the middle of a word.
    send(8'hEE); send(8'hEE); send(8'hEE);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    check("midrst_idle_valid", word_valid, 32'd0);
    send(8'hA1); send(8'hB2); send(8'hC3);
    check("midrst_index3", byte_index, 32'd3);
    check("midrst_noval",  word_valid, 32'd0);
    send(8'hD4);
    check("midrst_valid", word_valid, 32'd1);
    check("midrst_word",  word,       32'hD4C3B2A1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_word_assembler
